// File: rtl/traffic_pkg.sv
// Shared types for the N-approach traffic-light controller: lamp codes,
// phase encoding and the lamp-vector packing helper.
package traffic_pkg;

  localparam int unsigned MAX_DIR    = 8;
  localparam int unsigned LAMP_VEC_W = 2 * MAX_DIR;

  localparam logic [1:0] LAMP_RED       = 2'b00;
  localparam logic [1:0] LAMP_YELLOW    = 2'b01;
  localparam logic [1:0] LAMP_GREEN     = 2'b10;
  localparam logic [1:0] LAMP_BLINK_RED = 2'b11;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  // Write one 2-bit lamp code into slot dir of a maximum-width lamp vector.
  function automatic logic [LAMP_VEC_W-1:0] put_lamp(input logic [LAMP_VEC_W-1:0] vec,
                                                     input int unsigned           dir,
                                                     input logic [1:0]            code);
    logic [LAMP_VEC_W-1:0] v;
    v = vec;
    v[2*dir +: 2] = code;
    return v;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Demand inputs and lamp/status outputs of the traffic-light controller.
// master = sensor/monitor side, slave = controller.
interface traffic_light_ctrl_if #(
  parameter int unsigned NUM_DIR = 2
) ();
  localparam int unsigned IDX_W = $clog2(NUM_DIR);

  logic [NUM_DIR-1:0]   sense;
  logic                 flash_req;
  logic [2*NUM_DIR-1:0] car_light;
  logic [2*NUM_DIR-1:0] ped_light;
  logic [IDX_W-1:0]     active_dir;
  logic [1:0]           phase;

  modport master (
    output sense, flash_req,
    input  car_light, ped_light, active_dir, phase
  );

  modport slave (
    input  sense, flash_req,
    output car_light, ped_light, active_dir, phase
  );
endinterface

// File: rtl/traffic_light_ctrl_rr_pick.sv
// Rotating-priority search: first set req bit starting at base, wrapping
// around once. grant falls back to base when nothing is requested.
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  int unsigned idx_s;

  always_comb begin
    grant   = base;
    any_req = 1'b0;
    idx_s   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_s = 32'(base) + k;
      if (idx_s >= N) idx_s = idx_s - N;
      if (!any_req && req[idx_s]) begin
        grant   = IW'(idx_s);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-approach traffic-light controller: round-robin service of latched demand,
// GREEN -> YELLOW -> ALLRED handover, and a night-flash mode entered via clearance.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR   = 2,
  parameter int unsigned GREEN_MIN = 14,
  parameter int unsigned YELLOW_T  = 5,
  parameter int unsigned ALLRED_T  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  traffic_light_ctrl_if.slave   bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIR);
  localparam int unsigned LAMP_W = 2 * NUM_DIR;
  localparam int unsigned MAX_GY = (GREEN_MIN > YELLOW_T) ? GREEN_MIN : YELLOW_T;
  localparam int unsigned MAX_T  = (MAX_GY > ALLRED_T) ? MAX_GY : ALLRED_T;
  localparam int unsigned CNT_W  = ($clog2(MAX_T) > 0) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  if (NUM_DIR < 2 || NUM_DIR > MAX_DIR) begin : g_bad_num_dir
    $error("traffic_light_ctrl: NUM_DIR must be in 2..8");
  end
  if (GREEN_MIN < 1) begin : g_bad_green
    $error("traffic_light_ctrl: GREEN_MIN must be >= 1");
  end
  if (YELLOW_T < 1) begin : g_bad_yellow
    $error("traffic_light_ctrl: YELLOW_T must be >= 1");
  end
  if (ALLRED_T < 1) begin : g_bad_allred
    $error("traffic_light_ctrl: ALLRED_T must be >= 1");
  end

  phase_e              phase_q,     phase_d;
  logic [IDX_W-1:0]    active_q,    active_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [NUM_DIR-1:0]  pending_q,   pending_d;
  logic [LAMP_W-1:0]   car_light_q, car_light_d;
  logic [LAMP_W-1:0]   ped_light_q, ped_light_d;

  logic [NUM_DIR-1:0]  act_mask;
  logic [NUM_DIR-1:0]  tgt_mask;
  logic [IDX_W-1:0]    search_base;
  logic [IDX_W-1:0]    grant;
  logic                others_pending;
  logic [IDX_W-1:0]    target;

  // Lamp decode for a given phase and owning direction; {ped, car}.
  function automatic logic [2*LAMP_W-1:0] decode(input phase_e           ph,
                                                 input logic [IDX_W-1:0] act);
    logic [LAMP_W-1:0] car;
    logic [LAMP_W-1:0] ped;
    logic [1:0]        cc;
    logic [1:0]        pc;
    logic              is_act;
    car = '0;
    ped = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      is_act = (IDX_W'(i) == act);
      cc     = LAMP_RED;
      pc     = LAMP_RED;
      case (ph)
        PH_GREEN: begin
          cc = is_act ? LAMP_GREEN : LAMP_RED;
          pc = is_act ? LAMP_RED   : LAMP_GREEN;
        end
        PH_YELLOW: begin
          cc = is_act ? LAMP_YELLOW : LAMP_RED;
          pc = is_act ? LAMP_RED    : LAMP_BLINK_RED;
        end
        PH_ALLRED: begin
          cc = LAMP_RED;
          pc = is_act ? LAMP_RED : LAMP_BLINK_RED;
        end
        PH_FLASH: begin
          cc = LAMP_BLINK_RED;
          pc = LAMP_RED;
        end
      endcase
      car = LAMP_W'(put_lamp(LAMP_VEC_W'(car), i, cc));
      ped = LAMP_W'(put_lamp(LAMP_VEC_W'(ped), i, pc));
    end
    return {ped, car};
  endfunction

  always_comb begin
    act_mask = '0;
    tgt_mask = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      act_mask[i] = (IDX_W'(i) == active_q);
      tgt_mask[i] = (IDX_W'(i) == target);
    end
  end

  assign search_base = (active_q == IDX_W'(NUM_DIR - 1)) ? '0 : active_q + IDX_W'(1);

  // Search starts after the active direction; its own request is masked out.
  rr_pick #(.N(NUM_DIR)) u_rr_pick (
    .req     (pending_q & ~act_mask),
    .base    (search_base),
    .grant   (grant),
    .any_req (others_pending)
  );

  assign target = others_pending ? grant : active_q;

  always_comb begin
    phase_d   = phase_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | (bus.sense & ~((phase_q == PH_GREEN) ? act_mask : '0));

    case (phase_q)
      PH_GREEN: begin
        if (cnt_q == GREEN_LAST) begin
          if (others_pending || bus.flash_req) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_YELLOW: begin
        if (cnt_q == YELLOW_LAST) begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_ALLRED: begin
        if (cnt_q == ALLRED_LAST) begin
          cnt_d = '0;
          if (bus.flash_req) begin
            phase_d = PH_FLASH;
          end else begin
            phase_d   = PH_GREEN;
            active_d  = target;
            pending_d = pending_d & ~tgt_mask;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_FLASH: begin
        cnt_d = '0;
        if (!bus.flash_req) phase_d = PH_ALLRED;
      end
    endcase

    {ped_light_d, car_light_d} = decode(phase_d, active_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q                    <= PH_GREEN;
      active_q                   <= '0;
      cnt_q                      <= '0;
      pending_q                  <= '0;
      {ped_light_q, car_light_q} <= decode(PH_GREEN, '0);
    end else begin
      phase_q     <= phase_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      car_light_q <= car_light_d;
      ped_light_q <= ped_light_d;
    end
  end

  assign bus.car_light  = car_light_q;
  assign bus.ped_light  = ped_light_q;
  assign bus.active_dir = active_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a 4-approach default instance and a
// 2-approach instance with 1-cycle phases.
module tb_traffic_light_ctrl;

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  traffic_light_ctrl_if #(.NUM_DIR(4)) if4 ();
  traffic_light_ctrl_if #(.NUM_DIR(2)) if2 ();

  traffic_light_ctrl #(.NUM_DIR(4)) u4 (
    .CLK (CLK),
    .RST (RST),
    .bus (if4)
  );

  traffic_light_ctrl #(.NUM_DIR(2), .GREEN_MIN(1), .YELLOW_T(1), .ALLRED_T(1)) u2 (
    .CLK (CLK),
    .RST (RST),
    .bus (if2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] ph, input logic [1:0] act,
                      input logic [7:0] car, input logic [7:0] ped);
    chk({tag, ".phase"}, 32'(if4.phase), 32'(ph));
    chk({tag, ".active"}, 32'(if4.active_dir), 32'(act));
    chk({tag, ".car"}, 32'(if4.car_light), 32'(car));
    chk({tag, ".ped"}, 32'(if4.ped_light), 32'(ped));
  endtask

  logic [1:0] exp2_ph  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic       exp2_act [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] exp2_car [6] = '{4'h2, 4'h1, 4'h0, 4'h8, 4'h4, 4'h0};

  initial begin
    RST           = 1'b1;
    if4.sense     = '0;
    if4.flash_req = 1'b0;
    if2.sense     = '0;
    if2.flash_req = 1'b0;
    steps(2);
    RST = 1'b0;

    // Reset state
    chk4("reset", 2'd0, 2'd0, 8'h02, 8'hA8);
    chk("reset2.car", 32'(if2.car_light), 32'h2);
    chk("reset2.ped", 32'(if2.ped_light), 32'h8);

    // No demand: green holds
    for (int c = 1; c <= 100; c++) begin
      step();
      chk($sformatf("hold.car@%0d", c), 32'(if4.car_light), 32'h02);
    end
    chk("hold.phase", 32'(if4.phase), 32'd0);

    // Single demand on dir2, pulsed at cycle 3
    RST = 1'b1;
    step();
    RST = 1'b0;
    steps(3);
    if4.sense = 4'b0100;
    step();
    if4.sense = '0;
    steps(9);
    chk("d2.c13.phase", 32'(if4.phase), 32'd0);
    for (int c = 14; c <= 22; c++) begin
      step();
      chk($sformatf("d2.phase@%0d", c), 32'(if4.phase), (c < 19) ? 32'd1 : (c < 22) ? 32'd2 : 32'd0);
      if (c == 14) chk4("d2.yellow", 2'd1, 2'd0, 8'h01, 8'hFC);
      if (c == 19) chk4("d2.allred", 2'd2, 2'd0, 8'h00, 8'hFC);
    end
    chk4("d2.green", 2'd0, 2'd2, 8'h20, 8'h8A);

    // Reset during YELLOW of dir2 clears pending demand
    if4.sense = 4'b0011;
    step();
    if4.sense = '0;
    steps(13);
    chk4("rstmid.yellow", 2'd1, 2'd2, 8'h10, 8'hCF);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk4("rstmid.reset", 2'd0, 2'd0, 8'h02, 8'hA8);
    steps(30);
    chk4("rstmid.hold", 2'd0, 2'd0, 8'h02, 8'hA8);

    // Simultaneous demand on dir3 and dir1: dir1 served first
    if4.sense = 4'b1010;
    step();
    if4.sense = '0;
    chk("rr.latch.phase", 32'(if4.phase), 32'd0);
    step();
    chk4("rr.yellow0", 2'd1, 2'd0, 8'h01, 8'hFC);
    steps(5);
    chk4("rr.allred0", 2'd2, 2'd0, 8'h00, 8'hFC);
    steps(3);
    chk4("rr.green1", 2'd0, 2'd1, 8'h08, 8'hA2);
    steps(13);
    chk("rr.g1.last.phase", 32'(if4.phase), 32'd0);
    step();
    chk4("rr.yellow1", 2'd1, 2'd1, 8'h04, 8'hF3);
    steps(8);
    chk4("rr.green3", 2'd0, 2'd3, 8'h80, 8'h2A);

    // Night flash requested mid-green
    steps(5);
    if4.flash_req = 1'b1;
    steps(8);
    chk("fl.c13.phase", 32'(if4.phase), 32'd0);
    step();
    chk("fl.c14.phase", 32'(if4.phase), 32'd1);
    steps(5);
    chk("fl.c19.phase", 32'(if4.phase), 32'd2);
    steps(2);
    chk("fl.c21.phase", 32'(if4.phase), 32'd2);
    step();
    chk4("fl.flash", 2'd3, 2'd3, 8'hFF, 8'h00);
    if4.sense = 4'b0010;
    step();
    if4.sense = '0;
    steps(4);
    chk4("fl.flash.hold", 2'd3, 2'd3, 8'hFF, 8'h00);
    if4.flash_req = 1'b0;
    step();
    chk4("fl.exit.allred", 2'd2, 2'd3, 8'h00, 8'h3F);
    steps(2);
    chk("fl.exit.c3.phase", 32'(if4.phase), 32'd2);
    step();
    chk4("fl.exit.green1", 2'd0, 2'd1, 8'h08, 8'hA2);

    // Flash with no pending demand returns to the same direction
    if4.flash_req = 1'b1;
    steps(22);
    chk4("fl2.flash", 2'd3, 2'd1, 8'hFF, 8'h00);
    if4.flash_req = 1'b0;
    step();
    chk("fl2.allred.phase", 32'(if4.phase), 32'd2);
    steps(3);
    chk4("fl2.green1", 2'd0, 2'd1, 8'h08, 8'hA2);

    // 2-approach, 1-cycle phases, both senses held high
    if2.sense = 2'b11;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk($sformatf("alt.phase@%0d", n), 32'(if2.phase), 32'(exp2_ph[(n-1)%6]));
      chk($sformatf("alt.active@%0d", n), 32'(if2.active_dir), 32'(exp2_act[(n-1)%6]));
      chk($sformatf("alt.car@%0d", n), 32'(if2.car_light), 32'(exp2_car[(n-1)%6]));
    end
    if2.sense = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
